// File: rtl/rf_scoreboard_regfile_pkg.sv
// Shared constants for the scoreboarded register file.
// Port-1 read selector encodings and scoreboard defaults live here only.
package rf_scoreboard_regfile_pkg;

  localparam logic RD1_3R = 1'b0;
  localparam logic RD1_RD = 1'b1;

  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_ADDR_W_DEF = 5;
  localparam int RF_PEND_W_DEF = 2;

endpackage

// File: rtl/rf_scoreboard_regfile_if.sv
// Read, writeback and issue signals between the ID/WB stages and the register file.
// master = pipeline side, slave = register file.
interface rf_scoreboard_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] rR1;
  logic [ADDR_W-1:0] rR2;
  logic              rd1_op;
  logic [DATA_W-1:0] rD1;
  logic [DATA_W-1:0] rD2;
  logic              we;
  logic [ADDR_W-1:0] wR;
  logic [DATA_W-1:0] wD;
  logic              iss_valid;
  logic              iss_we;
  logic [ADDR_W-1:0] iss_wR;
  logic              iss_ready;
  logic              hazard;

  modport master (
    output rR1, rR2, rd1_op, we, wR, wD, iss_valid, iss_we, iss_wR,
    input  rD1, rD2, iss_ready, hazard
  );

  modport slave (
    input  rR1, rR2, rd1_op, we, wR, wD, iss_valid, iss_we, iss_wR,
    output rD1, rD2, iss_ready, hazard
  );

endinterface

// File: rtl/rf_scoreboard_regfile_pend_cnt.sv
// rf_pend_cnt: saturating up/down counter tracking in-flight writes to one register.
// Simultaneous inc and dec cancel; dec at zero and inc at full are ignored.
module rf_pend_cnt #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              nonzero
);

  assign full    = &count;
  assign nonzero = |count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + PEND_W'(1);
    end else if (dec && !inc && nonzero) begin
      count <= count - PEND_W'(1);
    end
  end

endmodule

// File: rtl/rf_scoreboard_regfile.sv
// Register file with per-register pending-write scoreboard driving the ID hazard stall.
// Define RF_BYPASS_EN to forward same-cycle writeback data and credit it against hazards.
module rf_scoreboard_regfile
  import rf_scoreboard_regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int ADDR_W = RF_ADDR_W_DEF,
  parameter int PEND_W = RF_PEND_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_scoreboard_regfile_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem [NREG];
  logic [PEND_W-1:0] pend [NREG];
  logic [NREG-1:0]   full;
  logic [NREG-1:0]   nonzero;
  logic [ADDR_W-1:0] s1;
  logic [ADDR_W-1:0] s2;
  logic              fwd1;
  logic              fwd2;
  logic              haz1;
  logic              haz2;
  logic              fire;

  assign s1 = (bus.rd1_op == RD1_3R) ? bus.rR1 : bus.iss_wR;
  assign s2 = bus.rR2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we && bus.wR != '0) begin
      mem[bus.wR] <= bus.wD;
    end
  end

  assign fwd1 = BYPASS && bus.we && (bus.wR == s1) && (s1 != '0);
  assign fwd2 = BYPASS && bus.we && (bus.wR == s2) && (s2 != '0);

  assign bus.rD1 = (s1 == '0) ? '0 : (fwd1 ? bus.wD : mem[s1]);
  assign bus.rD2 = (s2 == '0) ? '0 : (fwd2 ? bus.wD : mem[s2]);

  // The last outstanding write landing this cycle is forwarded, so it no longer blocks.
  assign haz1 = nonzero[s1] && !(fwd1 && pend[s1] == PEND_W'(1));
  assign haz2 = nonzero[s2] && !(fwd2 && pend[s2] == PEND_W'(1));
  assign bus.hazard = haz1 || haz2;

  assign bus.iss_ready = bus.iss_valid && !bus.hazard &&
                         !(bus.iss_we && full[bus.iss_wR] &&
                           !(bus.we && bus.wR == bus.iss_wR));

  assign fire = bus.iss_ready && bus.iss_we && (bus.iss_wR != '0);

  for (genvar g = 0; g < NREG; g++) begin : g_pend
    if (g == 0) begin : g_zero
      assign pend[g]    = '0;
      assign full[g]    = 1'b0;
      assign nonzero[g] = 1'b0;
    end else begin : g_cnt
      logic inc;
      logic dec;
      assign inc = fire && (bus.iss_wR == ADDR_W'(g));
      assign dec = bus.we && (bus.wR == ADDR_W'(g));
      rf_pend_cnt #(
        .PEND_W(PEND_W)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inc),
        .dec     (dec),
        .count   (pend[g]),
        .full    (full[g]),
        .nonzero (nonzero[g])
      );
    end
  end

endmodule
